calc_core: RTL and testbench
============================

CALC_CORE -- requirements
Module: calc_core

Interface
REQ-001 SHALL have parameter NDIG, default 4, meaning the number of decimal digits per operand and result.
REQ-002 SHALL have parameter W, default 14, meaning the binary operand width, equal to ceil(log2(10^NDIG)).
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port digit_pulse, input, 1 bit: one-cycle pulse indicating a numeric key press from the keypad interface.
REQ-006 SHALL have port digit, input, 4 bits: key value, valid only while digit_pulse is high.
REQ-007 SHALL have port op_pulse, input, 1 bit: one-cycle pulse indicating an operation key press.
REQ-008 SHALL have port op, input, 2 bits: 00 add, 01 sub, 10 mul, 11 clear.
REQ-009 SHALL have port eq_pulse, input, 1 bit: one-cycle pulse indicating an equals key press.
REQ-010 SHALL have port disp_bcd, output, 4*NDIG bits: BCD display value, most significant digit in the top nibble.
REQ-011 SHALL have port disp_valid, output, 1 bit: one-cycle pulse when disp_bcd is updated with a result.
REQ-012 SHALL have port busy, output, 1 bit: high while in CALC or CONV.
REQ-013 SHALL have port err, output, 1 bit: high while in ERR.

Function
REQ-014 SHALL implement states ENTER_A, ENTER_B, CALC, CONV, SHOW and ERR.
REQ-015 SHALL resolve simultaneous pulses with priority clear > eq > op > digit; lower-priority pulses in the same cycle are dropped.
REQ-016 SHALL, on a clear (op_pulse with op=11) in any state, go to ENTER_A with operand A, operand B, digit count and disp_bcd all zero.
REQ-017 SHALL, in ENTER_A or ENTER_B, on digit_pulse with digit<=9 and count<NDIG, update operand = operand*10+digit, shift digit into disp_bcd from the LSB, and increment count.
REQ-018 SHALL ignore digit_pulse when digit>9 or count=NDIG.
REQ-019 SHALL, in ENTER_A, on op_pulse (op!=11), latch op, clear B and count, zero disp_bcd, and go to ENTER_B.
REQ-020 SHALL ignore eq_pulse in ENTER_A.
REQ-021 SHALL, in ENTER_B, on a further op_pulse, replace the latched op; entered B digits are kept.
REQ-022 SHALL, in ENTER_B, on eq_pulse, go to CALC.
REQ-023 SHALL, in CALC (exactly one cycle), compute the result into a 2W-bit value:
- add: A+B
- sub: A-B; A<B goes to ERR
- mul: A*B
REQ-024 SHALL go to ERR from CALC when the result > 10^NDIG-1; otherwise it SHALL start the converter and go to CONV.
REQ-025 SHALL, in CONV, run a serial binary-to-BCD conversion of W cycles, then load disp_bcd, pulse disp_valid for one cycle, set A=result, and go to SHOW.
REQ-026 SHALL give a total latency of W+2 clock edges from the edge sampling eq_pulse to disp_valid high.
REQ-027 SHALL drop all pulses except clear while in CALC or CONV.
REQ-028 SHALL, in SHOW, on digit_pulse, restart ENTER_A with A=digit, count=1 and disp_bcd=digit.
REQ-029 SHALL, in SHOW, on op_pulse (op!=11), chain the result as A and go to ENTER_B as in REQ-019.
REQ-030 SHALL ignore eq_pulse in SHOW.
REQ-031 SHALL, in ERR, hold disp_bcd at all 1s (0xF per nibble) and exit only on clear or reset.

Reset
REQ-032 SHALL, on rst high, asynchronously force state ENTER_A, A=B=0, count=0, disp_bcd=0, disp_valid=0, busy=0 and err=0.
REQ-033 SHALL abandon any conversion in progress on reset, with no disp_valid pulse.

Configuration
REQ-034 SHALL, when CALC_MUL_EN is defined, implement mul as in REQ-023.
REQ-035 SHALL, without CALC_MUL_EN, treat op=10 as ignored in all states (no state change), contain no multiplier, and use a W+1-bit result.

Structure
REQ-036 SHALL take the op encoding, the state enumeration, NDIG/W defaults and the constant MAX_VAL=10^NDIG-1 from a shared package calc_pkg.
REQ-037 SHALL place the serial double-dabble converter in sub-module bin2bcd_seq, with ports clk, rst, start, bin[W-1:0], bcd[4*NDIG-1:0] and done.

Verification
REQ-038 SHALL be verified with: 1,2,add,3,4,eq -> disp_valid after 16 cycles, disp_bcd=0x0046.
REQ-039 SHALL be verified with: 5,sub,9,eq -> err=1, disp_bcd=0xFFFF; then clear -> err=0, disp_bcd=0x0000.
REQ-040 SHALL be verified with: 9,9,9,9,add,1,eq -> ERR; and 2,5,mul,4,eq -> 0x0100 (with CALC_MUL_EN).
REQ-041 SHALL be verified with: digits 1,2,3,4,5 -> disp_bcd=0x1234; a digit value of 12 is ignored.
REQ-042 SHALL be verified with: 2,add,3,eq (0x0005), add,4,eq -> 0x0009; digit 7 in SHOW -> disp_bcd=0x0007.
REQ-043 SHALL be verified with: rst asserted mid-CONV -> all outputs zero at once, state ENTER_A, and no disp_valid pulse.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad calculator core.
package calc_pkg;

  localparam int unsigned NDIG_DEF = 4;
  localparam int unsigned W_DEF    = 14;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_CLR = 2'b11
  } calcOpE;

  typedef enum logic [2:0] {
    ENTER_A,
    ENTER_B,
    CALC,
    CONV,
    SHOW,
    ERR
  } calcStateE;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Largest displayable result for the default digit count
  localparam longint unsigned MAX_VAL = pow10(NDIG_DEF) - 1;

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial double-dabble converter: one binary bit per cycle, done pulses
// for one cycle W cycles after start, with bcd then holding the result.
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int unsigned NDIG = NDIG_DEF,
  parameter int unsigned W    = W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W-1:0]      bin,
  output logic [4*NDIG-1:0] bcd,
  output logic              done
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]      binSr;
  logic [4*NDIG-1:0] bcdSr;
  logic [4*NDIG-1:0] bcdAdj;
  logic [CW-1:0]     bitCnt;
  logic              doneR;

  // Add 3 to every nibble that would overflow past 9 on the next shift
  always_comb begin
    bcdAdj = bcdSr;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (bcdSr[4*i +: 4] >= 4'd5) bcdAdj[4*i +: 4] = bcdSr[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      binSr  <= '0;
      bcdSr  <= '0;
      bitCnt <= '0;
      doneR  <= 1'b0;
    end else if (start) begin
      binSr  <= bin;
      bcdSr  <= '0;
      bitCnt <= CW'(W);
      doneR  <= 1'b0;
    end else if (bitCnt != '0) begin
      binSr  <= {binSr[W-2:0], 1'b0};
      bcdSr  <= {bcdAdj[4*NDIG-2:0], binSr[W-1]};
      bitCnt <= bitCnt - CW'(1);
      doneR  <= (bitCnt == CW'(1));
    end else begin
      doneR  <= 1'b0;
    end
  end

  assign bcd  = bcdSr;
  assign done = doneR;

endmodule

// File: rtl/calc_core.sv
// Keypad calculator core: operand entry, one-cycle arithmetic, serial BCD
// display conversion. Define CALC_MUL_EN to enable the multiply operation.
module calc_core
  import calc_pkg::*;
#(
  parameter int unsigned NDIG = NDIG_DEF,
  parameter int unsigned W    = W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              digit_pulse,
  input  logic [3:0]        digit,
  input  logic              op_pulse,
  input  logic [1:0]        op,
  input  logic              eq_pulse,
  output logic [4*NDIG-1:0] disp_bcd,
  output logic              disp_valid,
  output logic              busy,
  output logic              err
);

`ifdef CALC_MUL_EN
  localparam int unsigned RW = 2 * W;
`else
  localparam int unsigned RW = W + 1;
`endif
  localparam int unsigned CW = $clog2(NDIG + 1);
  localparam longint unsigned MaxV = (NDIG == NDIG_DEF) ? MAX_VAL : pow10(NDIG) - 1;

  calcStateE         state, stateNext;
  calcOpE            opReg, opNext;
  logic [W-1:0]      opA, aNext;
  logic [W-1:0]      opB, bNext;
  logic [W-1:0]      resLow, resNext;
  logic [CW-1:0]     digCnt, cntNext;
  logic [4*NDIG-1:0] dispBcd, dispNext;
  logic              dispValidR, validNext;
  logic              busyR, errR;
  logic [RW-1:0]     calcRes;
  logic              convStart;
  logic              convDone;
  logic [4*NDIG-1:0] convBcd;

  logic              clrEv, opEv, digKey, digOk;
  logic [4*NDIG-1:0] dispShift;

  assign clrEv = op_pulse && (op == OP_CLR);
`ifdef CALC_MUL_EN
  assign opEv  = op_pulse && (op != OP_CLR);
`else
  assign opEv  = op_pulse && (op != OP_CLR) && (op != OP_MUL);
`endif
  assign digKey    = digit_pulse && (digit <= 4'd9);
  assign digOk     = digKey && (digCnt < CW'(NDIG));
  assign dispShift = {dispBcd[4*NDIG-5:0], digit};

  // Next-state and datapath: priority clear > eq > op > digit
  always_comb begin
    stateNext = state;
    opNext    = opReg;
    aNext     = opA;
    bNext     = opB;
    resNext   = resLow;
    cntNext   = digCnt;
    dispNext  = dispBcd;
    validNext = 1'b0;
    convStart = 1'b0;
    calcRes   = '0;

    if (clrEv) begin
      stateNext = ENTER_A;
      aNext     = '0;
      bNext     = '0;
      cntNext   = '0;
      dispNext  = '0;
    end else begin
      case (state)
        ENTER_A, ENTER_B: begin
          if (eq_pulse) begin
            if (state == ENTER_B) stateNext = CALC;
          end else if (opEv) begin
            opNext = calcOpE'(op);
            if (state == ENTER_A) begin
              bNext     = '0;
              cntNext   = '0;
              dispNext  = '0;
              stateNext = ENTER_B;
            end
          end else if (digOk) begin
            if (state == ENTER_A) aNext = W'(opA * W'(10)) + W'(digit);
            else                  bNext = W'(opB * W'(10)) + W'(digit);
            dispNext = dispShift;
            cntNext  = digCnt + CW'(1);
          end
        end

        CALC: begin
          case (opReg)
            OP_ADD: calcRes = RW'(opA) + RW'(opB);
            OP_SUB: calcRes = RW'(opA - opB);
`ifdef CALC_MUL_EN
            OP_MUL: calcRes = RW'(opA) * RW'(opB);
`endif
            default: calcRes = '0;
          endcase
          if (((opReg == OP_SUB) && (opA < opB)) || (calcRes > RW'(MaxV))) begin
            stateNext = ERR;
            dispNext  = '1;
          end else begin
            convStart = 1'b1;
            resNext   = calcRes[W-1:0];
            stateNext = CONV;
          end
        end

        CONV: begin
          if (convDone) begin
            dispNext  = convBcd;
            validNext = 1'b1;
            aNext     = resLow;
            stateNext = SHOW;
          end
        end

        SHOW: begin
          if (eq_pulse) begin
            stateNext = SHOW;
          end else if (opEv) begin
            opNext    = calcOpE'(op);
            bNext     = '0;
            cntNext   = '0;
            dispNext  = '0;
            stateNext = ENTER_B;
          end else if (digKey) begin
            aNext     = W'(digit);
            cntNext   = CW'(1);
            dispNext  = (4*NDIG)'(digit);
            stateNext = ENTER_A;
          end
        end

        ERR:     stateNext = ERR;
        default: stateNext = ENTER_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ENTER_A;
      opReg      <= OP_ADD;
      opA        <= '0;
      opB        <= '0;
      resLow     <= '0;
      digCnt     <= '0;
      dispBcd    <= '0;
      dispValidR <= 1'b0;
      busyR      <= 1'b0;
      errR       <= 1'b0;
    end else begin
      state      <= stateNext;
      opReg      <= opNext;
      opA        <= aNext;
      opB        <= bNext;
      resLow     <= resNext;
      digCnt     <= cntNext;
      dispBcd    <= dispNext;
      dispValidR <= validNext;
      busyR      <= (stateNext == CALC) || (stateNext == CONV);
      errR       <= (stateNext == ERR);
    end
  end

  bin2bcd_seq #(.NDIG(NDIG), .W(W)) uConv (
    .clk   (clk),
    .rst   (rst),
    .start (convStart),
    .bin   (calcRes[W-1:0]),
    .bcd   (convBcd),
    .done  (convDone)
  );

  assign disp_bcd   = dispBcd;
  assign disp_valid = dispValidR;
  assign busy       = busyR;
  assign err        = errR;

endmodule

// File: tb/tb_calc_core.sv
// Directed, table-driven bench for calc_core with hand-computed expectations.
module tb_calc_core;
  import calc_pkg::*;

  localparam int unsigned NDIG = 4;
  localparam int unsigned W    = 14;
  localparam int LAT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        digit_pulse;
  logic [3:0]  digit;
  logic        op_pulse;
  logic [1:0]  op;
  logic        eq_pulse;
  logic [15:0] disp_bcd;
  logic        disp_valid;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  calc_core #(.NDIG(NDIG), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .digit_pulse (digit_pulse),
    .digit       (digit),
    .op_pulse    (op_pulse),
    .op          (op),
    .eq_pulse    (eq_pulse),
    .disp_bcd    (disp_bcd),
    .disp_valid  (disp_valid),
    .busy        (busy),
    .err         (err)
  );

  typedef enum int {K_DIG, K_OP, K_EQ, K_EQI} keyE;
  typedef struct {
    keyE         kind;
    logic [3:0]  val;
    logic [15:0] expDisp;
    logic        expErr;
  } vecT;

  vecT vecs[$];
  int  checks = 0;
  int  errors = 0;

  function automatic void addVec(input keyE k, input logic [3:0] v, input logic [15:0] d, input logic e);
    vecT t;
    t.kind = k; t.val = v; t.expDisp = d; t.expErr = e;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic dp, input logic [3:0] d, input logic opp, input logic [1:0] o, input logic eqp);
    @(negedge clk);
    digit_pulse = dp; digit = d; op_pulse = opp; op = o; eq_pulse = eqp;
    @(posedge clk); #1;
    digit_pulse = 1'b0; op_pulse = 1'b0; eq_pulse = 1'b0;
  endtask

  task automatic waitValid(output int lat);
    lat = 0;
    while (!disp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic noValid(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (disp_valid) seen++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;
    rst = 1'b1; digit_pulse = 1'b0; digit = 4'd0; op_pulse = 1'b0; op = 2'd0; eq_pulse = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_disp", 32'(disp_bcd), 32'h0);
    check("rst_valid", 32'(disp_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    @(negedge clk) rst = 1'b0;

    // Key sequence table: {key, value, expected display, expected err}
    addVec(K_OP, 4'd3, 16'h0000, 1'b0);
    addVec(K_DIG, 4'd1, 16'h0001, 1'b0); addVec(K_DIG, 4'd2, 16'h0012, 1'b0);
    addVec(K_OP, 4'd0, 16'h0000, 1'b0);
    addVec(K_DIG, 4'd3, 16'h0003, 1'b0); addVec(K_DIG, 4'd4, 16'h0034, 1'b0);
    addVec(K_EQ, 4'd0, 16'h0046, 1'b0);
    addVec(K_OP, 4'd3, 16'h0000, 1'b0);
    addVec(K_DIG, 4'd5, 16'h0005, 1'b0); addVec(K_OP, 4'd1, 16'h0000, 1'b0);
    addVec(K_DIG, 4'd9, 16'h0009, 1'b0);
    addVec(K_EQ, 4'd0, 16'hFFFF, 1'b1);
    addVec(K_DIG, 4'd1, 16'hFFFF, 1'b1); addVec(K_OP, 4'd0, 16'hFFFF, 1'b1);
    addVec(K_OP, 4'd3, 16'h0000, 1'b0);
    addVec(K_DIG, 4'd9, 16'h0009, 1'b0); addVec(K_DIG, 4'd9, 16'h0099, 1'b0);
    addVec(K_DIG, 4'd9, 16'h0999, 1'b0); addVec(K_DIG, 4'd9, 16'h9999, 1'b0);
    addVec(K_DIG, 4'd9, 16'h9999, 1'b0);
    addVec(K_OP, 4'd0, 16'h0000, 1'b0); addVec(K_DIG, 4'd1, 16'h0001, 1'b0);
    addVec(K_EQ, 4'd0, 16'hFFFF, 1'b1);
    addVec(K_OP, 4'd3, 16'h0000, 1'b0);
    addVec(K_DIG, 4'd1, 16'h0001, 1'b0); addVec(K_DIG, 4'd12, 16'h0001, 1'b0);
    addVec(K_DIG, 4'd2, 16'h0012, 1'b0); addVec(K_DIG, 4'd3, 16'h0123, 1'b0);
    addVec(K_DIG, 4'd4, 16'h1234, 1'b0); addVec(K_DIG, 4'd5, 16'h1234, 1'b0);
    addVec(K_EQI, 4'd0, 16'h1234, 1'b0);
    addVec(K_OP, 4'd3, 16'h0000, 1'b0);
    addVec(K_DIG, 4'd2, 16'h0002, 1'b0); addVec(K_OP, 4'd0, 16'h0000, 1'b0);
    addVec(K_DIG, 4'd3, 16'h0003, 1'b0); addVec(K_EQ, 4'd0, 16'h0005, 1'b0);
    addVec(K_EQI, 4'd0, 16'h0005, 1'b0);
    addVec(K_OP, 4'd0, 16'h0000, 1'b0); addVec(K_DIG, 4'd4, 16'h0004, 1'b0);
    addVec(K_EQ, 4'd0, 16'h0009, 1'b0);
    addVec(K_DIG, 4'd7, 16'h0007, 1'b0); addVec(K_DIG, 4'd8, 16'h0078, 1'b0);
    addVec(K_OP, 4'd3, 16'h0000, 1'b0);
    addVec(K_DIG, 4'd9, 16'h0009, 1'b0); addVec(K_OP, 4'd1, 16'h0000, 1'b0);
    addVec(K_DIG, 4'd5, 16'h0005, 1'b0); addVec(K_EQ, 4'd0, 16'h0004, 1'b0);
    addVec(K_OP, 4'd1, 16'h0000, 1'b0); addVec(K_DIG, 4'd4, 16'h0004, 1'b0);
    addVec(K_EQ, 4'd0, 16'h0000, 1'b0);
    addVec(K_OP, 4'd3, 16'h0000, 1'b0);
    addVec(K_DIG, 4'd8, 16'h0008, 1'b0); addVec(K_OP, 4'd1, 16'h0000, 1'b0);
    addVec(K_DIG, 4'd3, 16'h0003, 1'b0); addVec(K_OP, 4'd0, 16'h0003, 1'b0);
    addVec(K_EQ, 4'd0, 16'h0011, 1'b0);
    addVec(K_OP, 4'd3, 16'h0000, 1'b0);
`ifdef CALC_MUL_EN
    addVec(K_DIG, 4'd2, 16'h0002, 1'b0); addVec(K_DIG, 4'd5, 16'h0025, 1'b0);
    addVec(K_OP, 4'd2, 16'h0000, 1'b0); addVec(K_DIG, 4'd4, 16'h0004, 1'b0);
    addVec(K_EQ, 4'd0, 16'h0100, 1'b0);
`else
    addVec(K_DIG, 4'd2, 16'h0002, 1'b0); addVec(K_DIG, 4'd5, 16'h0025, 1'b0);
    addVec(K_OP, 4'd2, 16'h0025, 1'b0); addVec(K_DIG, 4'd4, 16'h0254, 1'b0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].kind)
        K_DIG: pulse(1'b1, vecs[i].val, 1'b0, 2'd0, 1'b0);
        K_OP:  pulse(1'b0, 4'd0, 1'b1, vecs[i].val[1:0], 1'b0);
        K_EQ: begin
          pulse(1'b0, 4'd0, 1'b0, 2'd0, 1'b1);
          if (!vecs[i].expErr) begin
            waitValid(lat);
            check($sformatf("lat_v%0d", i), 32'(lat), 32'(LAT));
          end else begin
            repeat (3) @(posedge clk);
            #1;
          end
        end
        default: begin
          pulse(1'b0, 4'd0, 1'b0, 2'd0, 1'b1);
          noValid(20, seen);
          check($sformatf("eqign_v%0d", i), 32'(seen), 32'h0);
        end
      endcase
      check($sformatf("disp_v%0d", i), 32'(disp_bcd), 32'(vecs[i].expDisp));
      check($sformatf("err_v%0d", i), 32'(err), 32'(vecs[i].expErr));
    end

    // Simultaneous pulses: op beats digit, clear beats everything
    pulse(1'b0, 4'd0, 1'b1, 2'd3, 1'b0);
    pulse(1'b1, 4'd5, 1'b0, 2'd0, 1'b0);
    pulse(1'b1, 4'd7, 1'b1, 2'd0, 1'b0);
    check("prio_op_digit", 32'(disp_bcd), 32'h0);
    pulse(1'b1, 4'd3, 1'b0, 2'd0, 1'b0);
    check("prio_b_entry", 32'(disp_bcd), 32'h0003);
    pulse(1'b1, 4'd9, 1'b1, 2'd1, 1'b1);
    waitValid(lat);
    check("prio_eq_lat", 32'(lat), 32'(LAT));
    check("prio_eq_res", 32'(disp_bcd), 32'h0008);
    pulse(1'b1, 4'd3, 1'b1, 2'd3, 1'b1);
    check("prio_clr", 32'(disp_bcd), 32'h0);

    // Pulses during conversion are dropped; disp_valid is one cycle wide
    pulse(1'b1, 4'd4, 1'b0, 2'd0, 1'b0);
    pulse(1'b0, 4'd0, 1'b1, 2'd0, 1'b0);
    pulse(1'b1, 4'd5, 1'b0, 2'd0, 1'b0);
    pulse(1'b0, 4'd0, 1'b0, 2'd0, 1'b1);
    check("busy_calc", 32'(busy), 32'h1);
    pulse(1'b1, 4'd1, 1'b0, 2'd0, 1'b0);
    pulse(1'b0, 4'd0, 1'b1, 2'd1, 1'b0);
    check("busy_conv", 32'(busy), 32'h1);
    waitValid(lat);
    check("conv_lat", 32'(lat), 32'(LAT - 2));
    check("conv_res", 32'(disp_bcd), 32'h0009);
    @(posedge clk); #1;
    check("valid_width", 32'(disp_valid), 32'h0);
    check("busy_show", 32'(busy), 32'h0);

    // Asynchronous reset in the middle of a conversion
    pulse(1'b0, 4'd0, 1'b1, 2'd3, 1'b0);
    pulse(1'b1, 4'd1, 1'b0, 2'd0, 1'b0);
    pulse(1'b0, 4'd0, 1'b1, 2'd0, 1'b0);
    pulse(1'b1, 4'd2, 1'b0, 2'd0, 1'b0);
    pulse(1'b0, 4'd0, 1'b0, 2'd0, 1'b1);
    repeat (5) @(posedge clk);
    #2;
    check("mid_busy", 32'(busy), 32'h1);
    check("mid_disp", 32'(disp_bcd), 32'h0002);
    rst = 1'b1;
    #1;
    check("arst_disp", 32'(disp_bcd), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_err", 32'(err), 32'h0);
    check("arst_valid", 32'(disp_valid), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    noValid(30, seen);
    check("arst_novalid", 32'(seen), 32'h0);
    pulse(1'b1, 4'd3, 1'b0, 2'd0, 1'b0);
    check("arst_entera", 32'(disp_bcd), 32'h0003);
    pulse(1'b0, 4'd0, 1'b0, 2'd0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("arst_eq_ign_busy", 32'(busy), 32'h0);
    check("arst_eq_ign_disp", 32'(disp_bcd), 32'h0003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
